// File: rtl/lisp_tx_dispatch.sv
// lisp_tx_dispatch
//   Buffers incoming packet words and per-packet forwarding rules, then
//   dispatches each packet to the output ports selected by its rule. Packets
//   with an empty bitmap are discarded. LISP packets (rule[19]) get a word-count
//   check against the byte length carried in the rule.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   pkt_in_valid   write strobe for pkt_in
//   pkt_in[138:0]  [138:136] 101 head / 100 body / 110 tail, [135:0] payload
//   rule_wr        rule strobe, same cycle as the tail word
//   rule[19:0]     [19] LISP flag, [18:8] byte length, [7:0] port bitmap
//   pkt_in_usedw   data buffer occupancy (saturates at 255); upstream stalls on bit 7
//   tx_port_ready  per-port "room for 128 words"
//   tx_valid       tx_data / tx_port_en carry a word this cycle
//   tx_data        outgoing word
//   tx_port_en     destination bitmap for tx_data
//   drop_cnt       packets discarded (wraps)
//   lisp_cnt       LISP packets sent (wraps)
//   len_err_cnt    LISP length mismatches (saturates)
//   sync_err       sticky buffer-overflow flag
//   dbg_state      current FSM state (0 IDLE, 1 CHECK, 2 SEND, 3 DROP)
//
// Handshake: a word is accepted on every rising edge where pkt_in_valid=1 and
// the data buffer is not full; there is no ready back to the source, flow
// control is by pkt_in_usedw[7]. On the output side tx_valid=1 means one word
// is presented for exactly that cycle; downstream cannot stall a packet once
// it has started, tx_port_ready only gates the start of a packet.
module lisp_tx_dispatch (
  input  logic         clk,
  input  logic         reset,
  input  logic         pkt_in_valid,
  input  logic [138:0] pkt_in,
  input  logic         rule_wr,
  input  logic [19:0]  rule,
  output logic [7:0]   pkt_in_usedw,
  input  logic [7:0]   tx_port_ready,
  output logic         tx_valid,
  output logic [138:0] tx_data,
  output logic [7:0]   tx_port_en,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  lisp_cnt,
  output logic [15:0]  len_err_cnt,
  output logic         sync_err,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, SEND = 2'd2, DROP = 2'd3} state_t;
  state_t state, state_n;

  // ---------------- data FIFO, 256 x 139, show-ahead ----------------
  logic [138:0] d_mem [256];
  logic [7:0]   d_wr_ptr, d_rd_ptr;
  logic [8:0]   d_cnt;
  logic         d_full, d_empty, d_wr, d_pop;
  logic [138:0] d_head;

  assign d_full  = (d_cnt == 9'd256);
  assign d_empty = (d_cnt == 9'd0);
  assign d_wr    = pkt_in_valid && !d_full;
  assign d_head  = d_mem[d_rd_ptr];
  assign pkt_in_usedw = d_cnt[8] ? 8'hFF : d_cnt[7:0];

  always_ff @(posedge clk) begin
    if (d_wr) d_mem[d_wr_ptr] <= pkt_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_wr_ptr <= '0;
      d_rd_ptr <= '0;
      d_cnt    <= '0;
    end else begin
      if (d_wr)  d_wr_ptr <= d_wr_ptr + 8'd1;
      if (d_pop) d_rd_ptr <= d_rd_ptr + 8'd1;
      d_cnt <= d_cnt + {8'd0, d_wr} - {8'd0, d_pop};
    end
  end

  // ---------------- rule FIFO, 16 x 20, show-ahead ----------------
  logic [19:0] r_mem [16];
  logic [3:0]  r_wr_ptr, r_rd_ptr;
  logic [4:0]  r_cnt;
  logic        r_full, r_empty, r_wr, r_pop;
  logic [19:0] r_head;
  logic        rule_ne_q;

  assign r_full  = (r_cnt == 5'd16);
  assign r_empty = (r_cnt == 5'd0);
  assign r_wr    = rule_wr && !r_full;
  assign r_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (r_wr) r_mem[r_wr_ptr] <= rule;
  end

  // rule_ne_q is a registered "rule available" flag: it gives the rule FIFO a
  // one-cycle write-to-read latency, which sets the rule_wr -> first word
  // latency to 4 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      rule_ne_q <= 1'b0;
    end else begin
      if (r_wr)  r_wr_ptr <= r_wr_ptr + 4'd1;
      if (r_pop) r_rd_ptr <= r_rd_ptr + 4'd1;
      r_cnt     <= r_cnt + {4'd0, r_wr} - {4'd0, r_pop};
      rule_ne_q <= !r_empty;
    end
  end

  // ---------------- dispatch FSM ----------------
  logic [19:0]  cur_rule;
  logic [10:0]  word_cnt, word_cnt_n, word_cnt_inc;
  logic [11:0]  exp_words;
  logic         is_tail;
  logic         latch_rule;
  logic         tx_valid_n;
  logic [7:0]   tx_en_n;
  logic [138:0] tx_data_n;
  logic         drop_inc, lisp_inc, len_err_inc;

  assign is_tail      = (d_head[138:136] == 3'b110);
  assign word_cnt_inc = word_cnt + 11'd1;
  // Expected word count: byte length rounded up to 16-byte words.
  assign exp_words    = ({1'b0, cur_rule[18:8]} + 12'd15) >> 4;
  assign dbg_state    = state;

  always_comb begin
    state_n     = state;
    r_pop       = 1'b0;
    d_pop       = 1'b0;
    latch_rule  = 1'b0;
    tx_valid_n  = 1'b0;
    tx_en_n     = 8'd0;
    tx_data_n   = tx_data;
    word_cnt_n  = word_cnt;
    drop_inc    = 1'b0;
    lisp_inc    = 1'b0;
    len_err_inc = 1'b0;
    case (state)
      IDLE: begin
        if (rule_ne_q && !r_empty) begin
          r_pop      = 1'b1;
          latch_rule = 1'b1;
          word_cnt_n = 11'd0;
          state_n    = CHECK;
        end
      end
      CHECK: begin
        if (cur_rule[7:0] == 8'd0)
          state_n = DROP;
        else if ((tx_port_ready & cur_rule[7:0]) == cur_rule[7:0])
          state_n = SEND;
      end
      SEND: begin
        // An empty buffer here is an upstream protocol error: wait for data.
        if (!d_empty) begin
          d_pop      = 1'b1;
          tx_valid_n = 1'b1;
          tx_en_n    = cur_rule[7:0];
          tx_data_n  = d_head;
          word_cnt_n = word_cnt_inc;
          if (is_tail) begin
            state_n = IDLE;
            if (cur_rule[19]) begin
              lisp_inc = 1'b1;
              if ({1'b0, word_cnt_inc} != exp_words) len_err_inc = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!d_empty) begin
          d_pop = 1'b1;
          if (is_tail) begin
            drop_inc = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur_rule    <= '0;
      word_cnt    <= '0;
      tx_valid    <= 1'b0;
      tx_port_en  <= '0;
      tx_data     <= '0;
      drop_cnt    <= '0;
      lisp_cnt    <= '0;
      len_err_cnt <= '0;
      sync_err    <= 1'b0;
    end else begin
      state      <= state_n;
      word_cnt   <= word_cnt_n;
      tx_valid   <= tx_valid_n;
      tx_port_en <= tx_en_n;
      tx_data    <= tx_data_n;
      if (latch_rule) cur_rule <= r_head;
      if (drop_inc)   drop_cnt <= drop_cnt + 32'd1;
      if (lisp_inc)   lisp_cnt <= lisp_cnt + 32'd1;
      if (len_err_inc && (len_err_cnt != 16'hFFFF)) len_err_cnt <= len_err_cnt + 16'd1;
      if ((pkt_in_valid && d_full) || (rule_wr && r_full)) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lisp_tx_dispatch.sv
// tb_lisp_tx_dispatch
//   Self-checking bench for lisp_tx_dispatch. A packet-level model predicts,
//   for every packet handed to the DUT, the exact sequence of {port_en, word}
//   beats it must emit (or a drop) and the resulting counter values; a
//   compare process checks every output cycle against that queue. Directed
//   sections pin latency, gaps, backpressure, overflow and reset behaviour
//   with hand-computed literals.
module tb_lisp_tx_dispatch;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pkt_in_valid = 1'b0;
  logic [138:0] pkt_in = '0;
  logic         rule_wr = 1'b0;
  logic [19:0]  rule = '0;
  logic [7:0]   tx_port_ready = 8'hFF;
  logic [7:0]   pkt_in_usedw;
  logic         tx_valid;
  logic [138:0] tx_data;
  logic [7:0]   tx_port_en;
  logic [31:0]  drop_cnt;
  logic [31:0]  lisp_cnt;
  logic [15:0]  len_err_cnt;
  logic         sync_err;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  lisp_tx_dispatch dut (
    .clk(clk), .reset(reset), .pkt_in_valid(pkt_in_valid), .pkt_in(pkt_in),
    .rule_wr(rule_wr), .rule(rule), .pkt_in_usedw(pkt_in_usedw),
    .tx_port_ready(tx_port_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_port_en(tx_port_en), .drop_cnt(drop_cnt), .lisp_cnt(lisp_cnt),
    .len_err_cnt(len_err_cnt), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model / scoreboard ----------------
  logic [146:0] exp_q[$];      // {port_en, word} in emission order
  int exp_drop = 0, exp_lisp = 0, exp_len_err = 0;
  int rules_sent = 0;
  int last_rule_cyc = 0;
  bit rand_ready = 1'b0;

  // observed output history
  int beats = 0, tails = 0, last_cyc = 0;
  bit in_pkt = 1'b0;
  int head_cyc[$];
  int tail_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [135:0] rand136();
    logic [135:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [146:0] e;
    if (!reset) in_pkt = 1'b0;
    if (tx_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got en %0h data %0h, expected no beat", tx_port_en, tx_data);
      end else begin
        e = exp_q.pop_front();
        if ({tx_port_en, tx_data} !== e) begin
          n_fail++;
          $display("FAIL tx_beat: got en %0h data %0h, expected en %0h data %0h",
                   tx_port_en, tx_data, e[146:139], e[138:0]);
        end
      end
      beats++;
      if (tx_data[138:136] == 3'b101) begin
        head_cyc.push_back(cyc);
        in_pkt = 1'b1;
      end else begin
        // no bubbles inside a packet
        n_checks++;
        if (!in_pkt || cyc != last_cyc + 1) begin
          n_fail++;
          $display("FAIL tx_contig: beat at cycle %0d, expected cycle %0d", cyc, last_cyc + 1);
        end
      end
      if (tx_data[138:136] == 3'b110) begin
        tail_cyc.push_back(cyc);
        tails++;
        in_pkt = 1'b0;
      end
      last_cyc = cyc;
    end else begin
      n_checks++;
      if (tx_port_en !== 8'd0) begin
        n_fail++;
        $display("FAIL idle_port_en: got %0h, expected 0", tx_port_en);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sends one n-word packet with its rule on the tail and records the
  // expected outcome in the model.
  task automatic send_pkt(input int n, input logic [19:0] r, input bit honor_stall);
    logic [138:0] w;
    int len;
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (honor_stall && pkt_in_usedw[7] && guard < 2000) begin
        pkt_in_valid = 1'b0;
        rule_wr = 1'b0;
        tick();
        guard++;
      end
      if (guard >= 2000) check("stall_timeout", 1, 0);
      w[138:136] = (i == 0) ? 3'b101 : ((i == n - 1) ? 3'b110 : 3'b100);
      w[135:0]   = rand136();
      pkt_in_valid = 1'b1;
      pkt_in  = w;
      rule_wr = (i == n - 1);
      rule    = r;
      if (r[7:0] != 8'd0) exp_q.push_back({r[7:0], w});
      tick();
    end
    pkt_in_valid = 1'b0;
    rule_wr = 1'b0;
    last_rule_cyc = cyc;
    rules_sent++;
    len = int'(r[18:8]);
    if (r[7:0] == 8'd0) exp_drop++;
    else if (r[19]) begin
      exp_lisp++;
      if ((len + 15) / 16 != n && exp_len_err < 65535) exp_len_err++;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || int'(drop_cnt) != exp_drop || pkt_in_usedw != 8'd0) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) check("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    check({tag, "_lisp_cnt"}, 64'(lisp_cnt), 64'(exp_lisp));
    check({tag, "_len_err_cnt"}, 64'(len_err_cnt), 64'(exp_len_err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx, n0, guard, n, len;
    logic [19:0] r;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 64'(tx_valid), 0);
    check("rst_usedw", 64'(pkt_in_usedw), 0);
    check("rst_counters", 64'({drop_cnt, lisp_cnt} | 64'(len_err_cnt)), 0);
    check("rst_sync_err", 64'(sync_err), 0);
    check("rst_tx_data", 64'(tx_data[63:0]), 0);
    reset = 1'b1;
    repeat (2) tick();

    // unicast, latency and 4 contiguous beats
    idx = head_cyc.size();
    send_pkt(4, 20'h00004, 1'b0);
    wait_drain();
    if (head_cyc.size() > idx && tail_cyc.size() > idx) begin
      check("uni_latency", 64'(head_cyc[idx] - last_rule_cyc), 4);
      check("uni_length", 64'(tail_cyc[idx] - head_cyc[idx]), 3);
    end else check("uni_seen", 0, 1);
    check("uni_lisp_cnt", 64'(lisp_cnt), 0);

    // LISP, matching then mismatching length
    send_pkt(6, {1'b1, 11'd90, 8'h03}, 1'b0);
    wait_drain();
    check("lisp_cnt_1", 64'(lisp_cnt), 1);
    check("lisp_len_err_0", 64'(len_err_cnt), 0);
    send_pkt(6, {1'b1, 11'd120, 8'h03}, 1'b0);
    wait_drain();
    check("lisp_cnt_2", 64'(lisp_cnt), 2);
    check("lisp_len_err_1", 64'(len_err_cnt), 1);

    // discard
    n0 = beats;
    send_pkt(3, 20'h00000, 1'b0);
    wait_drain();
    check("drop_cnt_1", 64'(drop_cnt), 1);
    check("drop_usedw", 64'(pkt_in_usedw), 0);
    check("drop_no_beats", 64'(beats), 64'(n0));

    // backpressure before start, ready drop mid-packet
    tx_port_ready = 8'h01;
    n0 = beats;
    send_pkt(5, 20'h00081, 1'b0);
    repeat (10) tick();
    check("bp_hold", 64'(beats), 64'(n0));
    tx_port_ready = 8'h81;
    guard = 0;
    while (beats < n0 + 2 && guard < 50) begin tick(); guard++; end
    tx_port_ready = 8'h00;
    wait_drain();
    check("bp_full_packet", 64'(beats), 64'(n0 + 5));
    tx_port_ready = 8'hFF;

    // back-to-back: three queued packets, 2-cycle gaps
    tx_port_ready = 8'h00;
    idx = head_cyc.size();
    send_pkt(3, 20'h00011, 1'b0);
    send_pkt(4, 20'h00002, 1'b0);
    send_pkt(2, 20'h000F0, 1'b0);
    tx_port_ready = 8'hFF;
    wait_drain();
    if (head_cyc.size() >= idx + 3 && tail_cyc.size() >= idx + 3) begin
      check("b2b_gap_1", 64'(head_cyc[idx + 1] - tail_cyc[idx]), 3);
      check("b2b_gap_2", 64'(head_cyc[idx + 2] - tail_cyc[idx + 1]), 3);
    end else check("b2b_seen", 0, 1);
    check_counters("directed");

    // randomized traffic with random port readiness
    rand_ready = 1'b1;
    fork
      begin
        while (rand_ready) begin
          tx_port_ready = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
          tick();
        end
        tx_port_ready = 8'hFF;
      end
    join_none
    for (int p = 0; p < 40; p++) begin
      guard = 0;
      while ((rules_sent - (tails + int'(drop_cnt))) >= 12 && guard < 5000) begin tick(); guard++; end
      if (guard >= 5000) check("rule_room_timeout", 1, 0);
      n = $urandom_range(2, 10);
      r = '0;
      r[7:0] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      r[19] = $urandom_range(0, 1);
      len = ($urandom_range(0, 1) == 1) ? (16 * n - $urandom_range(0, 15)) : $urandom_range(0, 2047);
      r[18:8] = 11'(len);
      send_pkt(n, r, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) tick();
    check_counters("random");
    check("random_sync_err", 64'(sync_err), 0);

    // reset in the middle of a packet being sent
    n0 = beats;
    send_pkt(20, 20'h00001, 1'b0);
    guard = 0;
    while (beats < n0 + 3 && guard < 50) begin tick(); guard++; end
    reset = 1'b0;
    exp_q.delete();
    exp_drop = 0; exp_lisp = 0; exp_len_err = 0;
    #1;
    check("midrst_tx_valid", 64'(tx_valid), 0);
    check("midrst_usedw", 64'(pkt_in_usedw), 0);
    tick();
    reset = 1'b1;
    n0 = beats;
    repeat (30) tick();
    check("midrst_no_more", 64'(beats), 64'(n0));

    // overflow: 257 words without rules
    for (int i = 0; i < 257; i++) begin
      pkt_in_valid = 1'b1;
      pkt_in = {3'b100, rand136()};
      tick();
    end
    pkt_in_valid = 1'b0;
    tick();
    check("ovf_usedw", 64'(pkt_in_usedw), 255);
    check("ovf_sync_err", 64'(sync_err), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("ovf_rst_usedw", 64'(pkt_in_usedw), 0);
    check("ovf_rst_sync_err", 64'(sync_err), 0);
    check_counters("ovf_rst");
    tick();
    reset = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lisp_tx_dispatch.md
LISP_TX_DISPATCH -- requirements
Module: lisp_tx_dispatch

Interface
REQ-001 SHALL have clk, input, 1: single clock; all logic on its rising edge.
REQ-002 SHALL have reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have pkt_in_valid, input, 1: pkt_in word write strobe.
REQ-004 SHALL have pkt_in, input, 139: packet word; [138:136] 101 = head, 100 = body, 110 = tail; [135:0] passed through unchanged.
REQ-005 SHALL have rule_wr, input, 1: rule strobe, asserted in the same cycle as the tail word.
REQ-006 SHALL have rule, input, 20: [19] LISP-encapsulated flag, [18:8] byte length (valid only when [19]=1), [7:0] output-port bitmap.
REQ-007 SHALL have pkt_in_usedw, output, 8: data-buffer occupancy in words; upstream stalls while bit 7 is 1.
REQ-008 SHALL have tx_port_ready, input, 8: per-port room for at least 128 words.
REQ-009 SHALL have tx_valid, output, 1: tx_data is valid this cycle.
REQ-010 SHALL have tx_data, output, 139: outgoing packet word.
REQ-011 SHALL have tx_port_en, output, 8: destination-port bitmap for tx_data (multicast allowed).
REQ-012 SHALL have drop_cnt, output, 32: number of packets discarded.
REQ-013 SHALL have lisp_cnt, output, 32: number of LISP packets sent.
REQ-014 SHALL have len_err_cnt, output, 16: number of LISP length mismatches.
REQ-015 SHALL have sync_err, output, 1: sticky flag for buffer overflow.

Function
REQ-016 SHALL buffer words in a 256x139 show-ahead data FIFO and rules in a 16x20 show-ahead rule FIFO.
REQ-017 SHALL drive pkt_in_usedw from the data FIFO used-word count, saturating at 255.
REQ-018 SHALL use FSM states IDLE, CHECK, SEND, DROP.
REQ-019 IDLE: when the rule FIFO is not empty, SHALL latch and pop the rule, then go to CHECK.
REQ-020 CHECK, bitmap==0: SHALL go to DROP.
REQ-021 CHECK, (tx_port_ready & bitmap)==bitmap: SHALL go to SEND; otherwise SHALL stay in CHECK with tx_valid=0.
REQ-022 SEND: each cycle SHALL pop one data word and register tx_data=word, tx_port_en=bitmap, tx_valid=1.
REQ-023 SEND: on the tail word SHALL go to IDLE; a packet is never interrupted once SEND starts, regardless of tx_port_ready.
REQ-024 DROP: each cycle SHALL pop one word with tx_valid=0; on the tail SHALL increment drop_cnt and go to IDLE.
REQ-025 Outside SEND, SHALL drive tx_valid=0 and tx_port_en=0; tx_data holds its last value.
REQ-026 Latency: with an idle FSM, empty queues and ready ports, the first tx_valid SHALL occur 4 cycles after the rule_wr edge.
REQ-027 Throughput: SHALL emit one word per cycle in SEND with no bubbles between words of the same packet.
REQ-028 LISP length check: for rule[19]=1, SHALL count words sent (11-bit) and compare at the tail against expected = (len+15)>>4.
REQ-029 On LISP length mismatch SHALL increment len_err_cnt, saturating at 0xFFFF; the packet is still sent in full.
REQ-030 On any LISP packet tail SHALL increment lisp_cnt.
REQ-031 drop_cnt and lisp_cnt SHALL wrap modulo 2^32.
REQ-032 Write to a full data FIFO: SHALL ignore the word and set sync_err.
REQ-033 Rule write to a full rule FIFO: SHALL ignore the rule and set sync_err.
REQ-034 sync_err SHALL clear only on reset.
REQ-035 Simultaneous write and pop on either FIFO SHALL be supported with occupancy unchanged.
REQ-036 Data FIFO empty in SEND or DROP before the tail: SHALL stall with no pop and tx_valid=0; this is a protocol error.

Reset
REQ-037 Reset assertion SHALL immediately force IDLE and zero tx_valid, tx_port_en, tx_data, drop_cnt, lisp_cnt, len_err_cnt, sync_err and the word counter.
REQ-038 Reset assertion SHALL immediately clear both FIFOs, so pkt_in_usedw=0.
REQ-039 Reset mid-packet SHALL discard the partial packet; no further words are output after deassertion.

Verification
REQ-040 Unicast: 4-word packet (101,100,100,110), rule=0x00004, all ports ready -> 4 consecutive tx_valid cycles starting 4 cycles after rule_wr, tx_port_en=0x04, words unchanged, lisp_cnt=0.
REQ-041 LISP: 6-word packet, rule={1,11'd90,8'h03} -> sent to ports 0 and 1, lisp_cnt=1, len_err_cnt=0; repeat with len=120 -> len_err_cnt=1 and packet still sent in full.
REQ-042 Discard: rule bitmap 0x00 on a 3-word packet -> no tx_valid, drop_cnt=1, pkt_in_usedw returns to 0.
REQ-043 Backpressure: bitmap 0x81, tx_port_ready=0x01 for 10 cycles then 0x81 -> tx_valid stays 0 until ready; the packet then goes out contiguously, and a later ready drop mid-packet does not stall it.
REQ-044 Overflow: write 257 words without rules -> pkt_in_usedw=255 and sync_err=1; then assert reset -> all counters 0, pkt_in_usedw=0, sync_err=0.
REQ-045 Back-to-back: three queued packets -> each goes out in order, with a 2-cycle gap (IDLE, CHECK) between each tail and the next head.
